// File: rtl/bcd_seg7_scan.sv
// Four-digit multiplexed 7-segment driver: latches BCD digits on load, scans them onto a shared bus.
// Optional build macro BLANK_LEADING_ZERO_EN blanks leading zero digits 3..1.
module bcd_seg7_scan #(
  parameter logic [25:0] SCAN_DIV       = 26'd50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] bcd,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        err
);

  localparam logic [25:0] CNT_LAST = SCAN_DIV - 26'd1;
  localparam logic        POL      = SEG_ACTIVE_LOW;

  logic [25:0] cnt;
  logic [1:0]  idx;
  logic [15:0] bcd_q;
  logic [3:0]  dp_q;
  logic [3:0]  cur_nib;
  logic        cur_dp;
  logic        blank;
  logic [6:0]  seg_hi;
  logic [3:0]  an_hi;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  function automatic logic any_bad(input logic [15:0] v);
    return (v[3:0] > 4'd9) || (v[7:4] > 4'd9) || (v[11:8] > 4'd9) || (v[15:12] > 4'd9);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 26'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd_q <= '0;
      dp_q  <= '0;
      err   <= 1'b0;
    end else if (load) begin
      bcd_q <= bcd;
      dp_q  <= dp_in;
      err   <= any_bad(bcd);
    end
  end

  always_comb begin
    cur_nib = bcd_q[3:0];
    cur_dp  = dp_q[0];
    blank   = 1'b0;
    case (idx)
      2'd0: begin
        cur_nib = bcd_q[3:0];
        cur_dp  = dp_q[0];
      end
      2'd1: begin
        cur_nib = bcd_q[7:4];
        cur_dp  = dp_q[1];
`ifdef BLANK_LEADING_ZERO_EN
        blank   = (bcd_q[15:4] == 12'h000);
`endif
      end
      2'd2: begin
        cur_nib = bcd_q[11:8];
        cur_dp  = dp_q[2];
`ifdef BLANK_LEADING_ZERO_EN
        blank   = (bcd_q[15:8] == 8'h00);
`endif
      end
      default: begin
        cur_nib = bcd_q[15:12];
        cur_dp  = dp_q[3];
`ifdef BLANK_LEADING_ZERO_EN
        blank   = (bcd_q[15:12] == 4'h0);
`endif
      end
    endcase
    seg_hi = blank ? 7'h00 : decode(cur_nib);
    an_hi  = 4'b0001 << idx;
  end

  // Outputs are registered together so an/seg/dp always describe the same digit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= {7{POL}};
      an  <= {4{POL}};
      dp  <= POL;
    end else begin
      seg <= seg_hi ^ {7{POL}};
      an  <= an_hi ^ {4{POL}};
      dp  <= cur_dp ^ POL;
    end
  end

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Randomized bench for bcd_seg7_scan (SCAN_DIV=4, active-low) against a behavioural display model.
module tb_bcd_seg7_scan;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] bcd;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  // Edges since reset release and the display contents the model believes are latched.
  int          n;
  logic [15:0] m_bcd;
  logic [3:0]  m_dp;

  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  bcd_seg7_scan #(.SCAN_DIV(26'd4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .load(load), .bcd(bcd), .dp_in(dp_in),
    .seg(seg), .dp(dp), .an(an), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic blank_model(input logic [15:0] v, input int d);
`ifdef BLANK_LEADING_ZERO_EN
    return (d != 0) && ((v >> (4 * d)) == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic bad_model(input logic [15:0] v);
    for (int k = 0; k < 4; k++)
      if (((v >> (4 * k)) & 16'hF) > 9) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      n     = 0;
      m_bcd = '0;
      m_dp  = '0;
    end else begin
      int         d;
      logic [3:0] nib;
      logic [6:0] e_seg;
      logic [3:0] e_an;
      logic       e_dp;
      logic       e_err;
      // Digit shown is fixed by elapsed time alone; content is whatever was latched before this edge.
      d     = (n / DIV) % 4;
      nib   = 4'((m_bcd >> (4 * d)) & 16'hF);
      e_seg = blank_model(m_bcd, d) ? 7'h7F : (~seg_tbl[nib] & 7'h7F);
      e_an  = 4'(~(1 << d)) & 4'hF;
      e_dp  = ~m_dp[d];
      if (load) begin
        m_bcd = bcd;
        m_dp  = dp_in;
      end
      e_err = bad_model(m_bcd);
      n++;
      #1;
      if (rst) begin
        chk("seg", {9'd0, seg}, {9'd0, e_seg});
        chk("an",  {12'd0, an}, {12'd0, e_an});
        chk("dp",  {15'd0, dp}, {15'd0, e_dp});
        chk("err", {15'd0, err}, {15'd0, e_err});
      end
    end
  end

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] p);
    @(negedge clk);
    load  = 1'b1;
    bcd   = v;
    dp_in = p;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_seg"}, {9'd0, seg}, 16'h007F);
    chk({tag, "_an"},  {12'd0, an}, 16'h000F);
    chk({tag, "_dp"},  {15'd0, dp}, 16'h0001);
    chk({tag, "_err"}, {15'd0, err}, 16'h0000);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] nb;
      if ($urandom % 8 == 0)      nb = 4'($urandom % 16);
      else if ($urandom % 3 == 0) nb = 4'd0;
      else                        nb = 4'($urandom % 10);
      v[4*k +: 4] = nb;
    end
    return v;
  endfunction

  initial begin
    rst   = 1'b0;
    load  = 1'b0;
    bcd   = '0;
    dp_in = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    idle(30);

    // Asynchronous reset in the middle of a digit slot.
    do_load(16'h9876, 4'b1111);
    idle(6);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b1;
    idle(10);

    do_load(16'h1234, 4'b0010);
    idle(20);
    do_load(16'h00A5, 4'b0000);
    idle(20);
    do_load(16'h0005, 4'b0001);
    idle(20);
    do_load(16'h0050, 4'b0100);
    idle(20);

    // Load coinciding with the prescaler terminal count.
    for (int t = 0; t < 4; t++) begin
      int guard = 0;
      @(negedge clk);
      while ((n % DIV) != DIV - 1 && guard < 16) begin
        @(negedge clk);
        guard++;
      end
      chk("tc_align_timeout", 16'(guard < 16), 16'd1);
      load  = 1'b1;
      bcd   = rand_bcd();
      dp_in = 4'($urandom % 16);
      @(negedge clk);
      load  = 1'b0;
      idle(9);
    end

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      load  = ($urandom % 5 == 0);
      bcd   = rand_bcd();
      dp_in = 4'($urandom % 16);
    end
    @(negedge clk);
    load = 1'b0;
    idle(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
